// File: rtl/mux_gate_unit_if.sv
// Operand/result handshake bundle for mux_gate_unit.
interface mux_gate_unit_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, y);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, y);
endinterface

// File: rtl/mux_gate_unit.sv
// Bitwise 2-input logic unit built from 2:1 muxes over a 4-entry truth table, one-deep output register.
// Optional MUX_GATE_CUSTOM_TT_EN adds a writable truth table used by op=7.
module mux_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mux_gate_unit_if.slave   bus,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  output logic [CNT_W-1:0] txn_count
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tt;
  logic [WIDTH-1:0] res;
  logic             accept, hs;

  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = !bus.out_valid || bus.out_ready;
  assign bus.y         = y_q;
  assign txn_count     = cnt_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign hs            = bus.out_valid && bus.out_ready;

`ifdef MUX_GATE_CUSTOM_TT_EN
  logic [3:0] cust_tt_q, cust_tt_d;

  // The write lands at the edge, so a beat accepted alongside it still sees the old table.
  assign cust_tt_d = cfg_we ? cfg_tt : cust_tt_q;

  always_ff @(posedge clk) begin
    if (rst) cust_tt_q <= 4'b0111;
    else     cust_tt_q <= cust_tt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_tt};
`endif

  always_comb begin
    tt = 4'b1000;
    case (bus.op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0111;
      3'd3: tt = 4'b0001;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
`ifdef MUX_GATE_CUSTOM_TT_EN
      3'd7: tt = cust_tt_q;
`else
      3'd7: tt = 4'b1100;
`endif
      default: tt = 4'b1000;
    endcase
  end

  // Table index is {a,b}: first mux on a picks the b=0/b=1 entries, final mux on b.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic lo, hi;
    assign lo     = bus.a[i] ? tt[2] : tt[0];
    assign hi     = bus.a[i] ? tt[3] : tt[1];
    assign res[i] = bus.b[i] ? hi : lo;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = accept ? FULL : EMPTY;
      FULL:    state_d = (hs && !accept) ? EMPTY : FULL;
      default: state_d = EMPTY;
    endcase
  end

  assign y_d   = accept ? res : y_q;
  assign cnt_d = hs ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux_gate_unit.sv
// Directed self-checking bench for mux_gate_unit (WIDTH=8, CNT_W=4).
module tb_mux_gate_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_tt;
  logic [3:0] txn_count;
  int checks = 0;
  int errors = 0;

  mux_gate_unit_if #(.WIDTH(8)) bus ();

  mux_gate_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_tt    (cfg_tt),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = av;
    bus.b        = bv;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_tt = 4'h0;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd1, 8'hFF, 8'hFF);
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y got %h want 00", bus.y); end
    checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL reset_txn got %0d want 0", txn_count); end
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_ops;
    logic [7:0] exp_y [7] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 3'(k), 8'hF0, 8'hCC);
      tick();
      checks++; if (bus.y !== exp_y[k] || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL op%0d y got %h/%b want %h/1", k, bus.y, bus.out_valid, exp_y[k]);
      end
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h0F) begin
      errors++; $display("FAIL ops_drain got %b/%h want 0/0f", bus.out_valid, bus.y);
    end
    checks++; if (txn_count !== 4'd7) begin errors++; $display("FAIL ops_txn got %0d want 7", txn_count); end
  endtask

  task automatic test_stall;
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd2, 8'hFF, 8'h0F);
    tick();
    checks++; if (bus.y !== 8'hF0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_first got %h/%b want f0/1", bus.y, bus.out_valid);
    end
    drive(1'b1, 3'd0, 8'hAA, 8'h55);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready); end
    tick();
    tick();
    checks++; if (bus.y !== 8'hF0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold got %h/%b want f0/1", bus.y, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.y !== 8'h00 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_second got %h/%b want 00/1", bus.y, bus.out_valid);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checks++; if (txn_count !== 4'd9 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_txn got %0d/%b want 9/0", txn_count, bus.out_valid);
    end
  endtask

  task automatic test_custom_tt;
    bus.out_ready = 1'b1;
`ifdef MUX_GATE_CUSTOM_TT_EN
    cfg_we = 1'b1;
    cfg_tt = 4'b0110;
    drive(1'b1, 3'd7, 8'h0F, 8'h33);
    tick();
    checks++; if (bus.y !== 8'hFC) begin errors++; $display("FAIL custom_old_table got %h want fc", bus.y); end
    cfg_we = 1'b0;
    cfg_tt = 4'b0000;
    tick();
    checks++; if (bus.y !== 8'h3C) begin errors++; $display("FAIL custom_new_table got %h want 3c", bus.y); end
`else
    cfg_we = 1'b1;
    cfg_tt = 4'b0000;
    drive(1'b1, 3'd7, 8'h5A, 8'hFF);
    tick();
    checks++; if (bus.y !== 8'h5A) begin errors++; $display("FAIL pass_a got %h want 5a", bus.y); end
    cfg_we = 1'b0;
    drive(1'b1, 3'd7, 8'h3C, 8'h81);
    tick();
    checks++; if (bus.y !== 8'h3C) begin errors++; $display("FAIL pass_a2 got %h want 3c", bus.y); end
`endif
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checks++; if (txn_count !== 4'd11) begin errors++; $display("FAIL custom_txn got %0d want 11", txn_count); end
  endtask

  task automatic test_back_to_back_wrap;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL wrap_reset got %0d want 0", txn_count); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 3'd4, 8'(k), 8'h0F);
      tick();
    end
    checks++; if (bus.y !== 8'h00 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_last got %h/%b want 00/1", bus.y, bus.out_valid);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d want 0", txn_count); end
    drive(1'b1, 3'd1, 8'h01, 8'h02);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL wrap_17 got %0d want 1", txn_count); end
  endtask

  task automatic test_rst_stall;
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd4, 8'h12, 8'h34);
    tick();
    checks++; if (bus.y !== 8'h26 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_stall_pre got %h/%b want 26/1", bus.y, bus.out_valid);
    end
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd1, 8'hFF, 8'h00);
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h00 || txn_count !== 4'd0) begin
      errors++; $display("FAIL rst_stall got %b/%h/%0d want 0/00/0", bus.out_valid, bus.y, txn_count);
    end
    rst = 1'b0;
    drive(1'b1, 3'd0, 8'hFF, 8'h0F);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_ready got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.y !== 8'h0F || bus.out_valid !== 1'b1 || txn_count !== 4'd0) begin
      errors++; $display("FAIL post_rst_accept got %h/%b/%0d want 0f/1/0", bus.y, bus.out_valid, txn_count);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    checks++; if (txn_count !== 4'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst_txn got %0d/%b want 1/0", txn_count, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_stall();
    test_custom_tt();
    test_back_to_back_wrap();
    test_rst_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
